// File: rtl/fec_decoder_if.sv
// Byte-stream handshake bundle between a codeword source, the SECDED decoder and its result sink.
interface fec_decoder_if;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_BYTE;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT_BYTE;

    modport master (
        output IN_VALID,
        output IN_BYTE,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  OUT_BYTE
    );

    modport slave (
        input  IN_VALID,
        input  IN_BYTE,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output OUT_BYTE
    );
endinterface

// File: rtl/fec_decoder.sv
// Hamming(16,11) SECDED decoder: takes a codeword as two bytes, returns data plus a status byte,
// and keeps saturating counts of corrected and uncorrectable codewords.
module fec_decoder (
    input  logic         CLK,
    input  logic         RESET,
    fec_decoder_if.slave bus,
    output logic [7:0]   CORR_CNT,
    output logic [7:0]   DERR_CNT
);
    typedef enum logic [2:0] {
        RX_LO = 3'd0,
        RX_HI = 3'd1,
        CALC  = 3'd2,
        TX_LO = 3'd3,
        TX_HI = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] code_r;
    logic [3:0]  syn_r;
    logic        par_r;
    logic        calc_phase_r;
    logic [10:0] data_r;
    logic [1:0]  status_r;
    logic [7:0]  out_byte_r;
    logic [7:0]  corr_cnt_r;
    logic [7:0]  derr_cnt_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [15:0] fixed_s;
    logic [10:0] dec_data_s;
    logic [1:0]  dec_status_s;

    function automatic logic [3:0] calc_syndrome(input logic [15:0] c);
        logic [3:0] s;
        logic [3:0] pos;
        s = 4'b0000;
        for (int k = 1; k < 16; k++) begin
            pos = k[3:0];
            for (int i = 0; i < 4; i++) begin
                s[i] = s[i] ^ (c[k] & pos[i]);
            end
        end
        return s;
    endfunction

    function automatic logic calc_parity(input logic [15:0] c);
        return ^c;
    endfunction

    function automatic logic [10:0] extract_data(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

    assign bus.IN_READY  = in_ready_r;
    assign bus.OUT_VALID = out_valid_r;
    assign bus.OUT_BYTE  = out_byte_r;
    assign CORR_CNT      = corr_cnt_r;
    assign DERR_CNT      = derr_cnt_r;

    // Correction from the syndrome registered in the first CALC cycle; odd parity means a single flip.
    always_comb begin
        fixed_s      = code_r;
        dec_status_s = 2'b00;
        if (par_r) begin
            fixed_s[syn_r] = ~code_r[syn_r];
            dec_status_s   = 2'b01;
        end else if (syn_r != 4'd0) begin
            dec_status_s = 2'b10;
        end else begin
            dec_status_s = 2'b00;
        end
        dec_data_s = extract_data(fixed_s);
    end

    // Next-state logic; CALC spans two cycles (syndrome, then correction).
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RX_LO:   if (bus.IN_VALID)  state_next_s = RX_HI; else state_next_s = RX_LO;
            RX_HI:   if (bus.IN_VALID)  state_next_s = CALC;  else state_next_s = RX_HI;
            CALC:    if (calc_phase_r)  state_next_s = TX_LO; else state_next_s = CALC;
            TX_LO:   if (bus.OUT_READY) state_next_s = TX_HI; else state_next_s = TX_LO;
            TX_HI:   if (bus.OUT_READY) state_next_s = RX_LO; else state_next_s = TX_HI;
            default: state_next_s = RX_LO;
        endcase
    end

    // State register and registered handshake outputs derived from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= RX_LO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == RX_LO) || (state_next_s == RX_HI);
            out_valid_r <= (state_next_s == TX_LO) || (state_next_s == TX_HI);
        end
    end

    // Codeword capture, decode pipeline, output byte and saturating error counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            code_r       <= 16'h0000;
            syn_r        <= 4'd0;
            par_r        <= 1'b0;
            calc_phase_r <= 1'b0;
            data_r       <= 11'd0;
            status_r     <= 2'b00;
            out_byte_r   <= 8'h00;
            corr_cnt_r   <= 8'd0;
            derr_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                RX_LO: begin
                    if (bus.IN_VALID) code_r[7:0] <= bus.IN_BYTE;
                end
                RX_HI: begin
                    if (bus.IN_VALID) code_r[15:8] <= bus.IN_BYTE;
                end
                CALC: begin
                    if (!calc_phase_r) begin
                        syn_r        <= calc_syndrome(code_r);
                        par_r        <= calc_parity(code_r);
                        calc_phase_r <= 1'b1;
                    end else begin
                        calc_phase_r <= 1'b0;
                        data_r       <= dec_data_s;
                        status_r     <= dec_status_s;
                        out_byte_r   <= dec_data_s[7:0];
                        if ((dec_status_s == 2'b01) && (corr_cnt_r != 8'hFF))
                            corr_cnt_r <= corr_cnt_r + 8'd1;
                        if ((dec_status_s == 2'b10) && (derr_cnt_r != 8'hFF))
                            derr_cnt_r <= derr_cnt_r + 8'd1;
                    end
                end
                TX_LO: begin
                    if (bus.OUT_READY) out_byte_r <= {status_r, 3'b000, data_r[10:8]};
                end
                TX_HI: begin
                    if (bus.OUT_READY) out_byte_r <= 8'h00;
                end
                default: begin
                    calc_phase_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fec_decoder.sv
// Self-checking bench for fec_decoder: directed vectors, corner sequences and randomized
// encode/corrupt/decode traffic against an encoder-based reference model.
module tb_fec_decoder;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] CORR_CNT;
    logic [7:0] DERR_CNT;

    fec_decoder_if bus();

    fec_decoder dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus),
        .CORR_CNT (CORR_CNT),
        .DERR_CNT (DERR_CNT)
    );

    always #5 CLK = ~CLK;

    localparam int BUDGET = 50;
    int checks = 0;
    int errors = 0;
    int model_corr = 0;
    int model_derr = 0;
    int dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
        int         kind;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c = 16'h0000;
        for (int j = 0; j < 11; j++) c[dpos[j]] = d[j];
        for (int i = 0; i < 4; i++) begin
            p = 1'b0;
            for (int k = 1; k < 16; k++)
                if (((k >> i) & 1) == 1) p = p ^ c[k];
            c[1 << i] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
        return d;
    endfunction

    task automatic model_count(input int kind);
        if (kind == 1 && model_corr < 255) model_corr++;
        if (kind == 2 && model_derr < 255) model_derr++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.IN_VALID = 1'b1;
        bus.IN_BYTE  = b;
        while (bus.IN_READY !== 1'b1 && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        if (n >= BUDGET) check("in_ready_timeout", {15'd0, bus.IN_READY}, 16'd1);
        else begin
            @(posedge CLK);
            #1;
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        int n;
        n = 0;
        repeat (stall) begin
            @(posedge CLK);
            #1;
        end
        bus.OUT_READY = 1'b1;
        while (bus.OUT_VALID !== 1'b1 && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        b = bus.OUT_BYTE;
        if (n >= BUDGET) check("out_valid_timeout", {15'd0, bus.OUT_VALID}, 16'd1);
        else begin
            @(posedge CLK);
            #1;
        end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic run_cw(input logic [7:0] lo, input logic [7:0] hi,
                          output logic [7:0] o_lo, output logic [7:0] o_hi, input int stall);
        send_byte(lo);
        send_byte(hi);
        recv_byte(o_lo, stall);
        recv_byte(o_hi, 0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_corr_cnt"}, {8'd0, CORR_CNT}, 16'(model_corr));
        check({tag, "_derr_cnt"}, {8'd0, DERR_CNT}, 16'(model_derr));
    endtask

    task automatic do_random(input int mode);
        logic [10:0] d;
        logic [15:0] c;
        logic [10:0] exp_d;
        logic [7:0]  o_lo, o_hi;
        int          e1, e2;
        d  = 11'($urandom);
        c  = encode(d);
        e1 = int'($urandom_range(0, 15));
        e2 = (e1 + int'($urandom_range(1, 15))) % 16;
        if (mode >= 1) c[e1] = ~c[e1];
        if (mode == 2) c[e2] = ~c[e2];
        exp_d = (mode == 2) ? extract(c) : d;
        run_cw(c[7:0], c[15:8], o_lo, o_hi, int'($urandom_range(0, 2)));
        model_count(mode);
        check("rand_lo", {8'd0, o_lo}, {8'd0, exp_d[7:0]});
        check("rand_hi", {8'd0, o_hi}, {8'd0, 2'(mode), 3'b000, exp_d[10:8]});
        check_counters("rand");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [7];
        logic [7:0] o_lo, o_hi;
        int         n;

        vecs[0] = '{8'h0F, 8'h00, 8'h01, 8'h00, 0};
        vecs[1] = '{8'h2F, 8'h00, 8'h01, 8'h40, 1};
        vecs[2] = '{8'h0E, 8'h00, 8'h01, 8'h40, 1};
        vecs[3] = '{8'h6F, 8'h00, 8'h07, 8'h80, 2};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h07, 0};
        vecs[5] = '{8'hFF, 8'h7F, 8'hFF, 8'h47, 1};
        vecs[6] = '{8'hFF, 8'h3F, 8'hFF, 8'h81, 2};

        RESET = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.IN_BYTE   = 8'h00;
        bus.OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("rst_in_ready", {15'd0, bus.IN_READY}, 16'd1);
        check("rst_out_valid", {15'd0, bus.OUT_VALID}, 16'd0);
        check("rst_out_byte", {8'd0, bus.OUT_BYTE}, 16'h0000);
        check_counters("rst");

        for (int i = 0; i < 7; i++) begin
            run_cw(vecs[i].lo, vecs[i].hi, o_lo, o_hi, i % 3);
            model_count(vecs[i].kind);
            check("vec_lo", {8'd0, o_lo}, {8'd0, vecs[i].exp_lo});
            check("vec_hi", {8'd0, o_hi}, {8'd0, vecs[i].exp_hi});
            check_counters("vec");
        end

        // Latency: high byte taken at edge N, first result byte valid after edge N+2.
        send_byte(8'h0F);
        bus.IN_VALID = 1'b1;
        bus.IN_BYTE  = 8'h00;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        check("lat_n_valid", {15'd0, bus.OUT_VALID}, 16'd0);
        check("lat_n_in_ready", {15'd0, bus.IN_READY}, 16'd0);
        @(posedge CLK);
        #1;
        check("lat_n1_valid", {15'd0, bus.OUT_VALID}, 16'd0);
        @(posedge CLK);
        #1;
        check("lat_n2_valid", {15'd0, bus.OUT_VALID}, 16'd1);
        check("lat_n2_byte", {8'd0, bus.OUT_BYTE}, 16'h0001);
        recv_byte(o_lo, 0);
        recv_byte(o_hi, 0);
        check("lat_lo", {8'd0, o_lo}, 16'h0001);
        check("lat_hi", {8'd0, o_hi}, 16'h0000);

        // Backpressure in TX_LO while a stray input byte is offered.
        send_byte(8'h0F);
        send_byte(8'h00);
        n = 0;
        while (bus.OUT_VALID !== 1'b1 && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("bp_reach_tx", {15'd0, bus.OUT_VALID}, 16'd1);
        bus.IN_VALID = 1'b1;
        bus.IN_BYTE  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check("bp_out_byte", {8'd0, bus.OUT_BYTE}, 16'h0001);
            check("bp_out_valid", {15'd0, bus.OUT_VALID}, 16'd1);
            check("bp_in_ready", {15'd0, bus.IN_READY}, 16'd0);
        end
        bus.IN_VALID = 1'b0;
        recv_byte(o_lo, 0);
        recv_byte(o_hi, 0);
        check("bp_lo", {8'd0, o_lo}, 16'h0001);
        check("bp_hi", {8'd0, o_hi}, 16'h0000);
        run_cw(8'h2F, 8'h00, o_lo, o_hi, 0);
        model_count(1);
        check("bp_next_lo", {8'd0, o_lo}, 16'h0001);
        check("bp_next_hi", {8'd0, o_hi}, 16'h0040);
        check_counters("bp");

        // Reset while a result is pending in TX_LO.
        send_byte(8'h2F);
        send_byte(8'h00);
        n = 0;
        while (bus.OUT_VALID !== 1'b1 && n < BUDGET) begin
            @(posedge CLK);
            #1;
            n++;
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_corr = 0;
        model_derr = 0;
        check("rtx_out_valid", {15'd0, bus.OUT_VALID}, 16'd0);
        check("rtx_in_ready", {15'd0, bus.IN_READY}, 16'd1);
        check("rtx_out_byte", {8'd0, bus.OUT_BYTE}, 16'h0000);
        check_counters("rtx");
        run_cw(8'h00, 8'h00, o_lo, o_hi, 0);
        check("rtx_lo", {8'd0, o_lo}, 16'h0000);
        check("rtx_hi", {8'd0, o_hi}, 16'h0000);

        // Reset after only the low byte: the partial codeword must be dropped.
        send_byte(8'h2F);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        run_cw(8'h0E, 8'h00, o_lo, o_hi, 0);
        model_count(1);
        check("rrx_lo", {8'd0, o_lo}, 16'h0001);
        check("rrx_hi", {8'd0, o_hi}, 16'h0040);
        check_counters("rrx");

        for (int i = 0; i < 300; i++) do_random(int'($urandom_range(0, 2)));
        for (int i = 0; i < 270; i++) do_random(1);
        for (int i = 0; i < 270; i++) do_random(2);
        check("sat_corr", {8'd0, CORR_CNT}, 16'd255);
        check("sat_derr", {8'd0, DERR_CNT}, 16'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fec_decoder.md
FEC_DECODER -- requirements
Module: fec_decoder

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port IN_VALID  input  1  IN_BYTE holds a valid codeword byte.
REQ-004 SHALL have port IN_READY  output  1  decoder accepts IN_BYTE this cycle.
REQ-005 SHALL have port IN_BYTE  input  8  codeword byte; low byte C[7:0] first, then high byte C[15:8].
REQ-006 SHALL have port OUT_VALID  output  1  OUT_BYTE holds a valid result byte.
REQ-007 SHALL have port OUT_READY  input  1  downstream accepts OUT_BYTE this cycle.
REQ-008 SHALL have port OUT_BYTE  output  8  result byte; data low byte first, then status/high byte.
REQ-009 SHALL have port CORR_CNT  output  8  count of single-error codewords, saturating at 255.
REQ-010 SHALL have port DERR_CNT  output  8  count of double-error codewords, saturating at 255.

Function
REQ-011 Codeword C[15:0] SHALL be Hamming(16,11) SECDED; bit k is position k; parity bits at positions 1, 2, 4, 8; overall parity at position 0.
REQ-012 Data d[10:0] SHALL occupy positions 3,5,6,7,9,10,11,12,13,14,15 (d0 at 3, d10 at 15).
REQ-013 Syndrome bit S[i] SHALL be the XOR of all C[k] where bit i of k is 1 (i = 0..3); P SHALL be the XOR of all 16 bits.
REQ-014 S=0, P=0 SHALL give status 2'b00, data extracted unchanged.
REQ-015 P=1 SHALL give status 2'b01: flip C[S] (S=0 flips the overall-parity bit), then extract data.
REQ-016 S!=0, P=0 SHALL give status 2'b10, data extracted uncorrected.
REQ-017 FSM states SHALL be RX_LO, RX_HI, CALC, TX_LO, TX_HI.
- RX_LO: IN_READY=1; on IN_VALID capture C[7:0] and go to RX_HI.
- RX_HI: IN_READY=1; on IN_VALID capture C[15:8] and go to CALC.
- CALC: IN_READY=0, OUT_VALID=0; register corrected data and status for one cycle; go to TX_LO.
- TX_LO: OUT_VALID=1, OUT_BYTE=d[7:0]; on OUT_READY go to TX_HI.
- TX_HI: OUT_VALID=1, OUT_BYTE={status[1:0],3'b000,d[10:8]}; on OUT_READY go to RX_LO.
REQ-018 In any state, absent IN_VALID or OUT_READY respectively, the FSM SHALL hold state and register contents.
REQ-019 IN_READY SHALL be 0 in CALC, TX_LO and TX_HI; input bytes offered then SHALL NOT be consumed.
REQ-020 Latency: high byte accepted at edge N -> OUT_VALID=1 with the low result byte after edge N+2.
REQ-021 OUT_BYTE SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 CORR_CNT/DERR_CNT SHALL increment by 1 on the CALC cycle for status 01/10; at 255 they SHALL hold.
REQ-023 Next-codeword capture SHALL NOT begin until TX_HI completes.

Reset
REQ-024 While RESET=1 at a clock edge: state=RX_LO, captured codeword and result registers=0, CORR_CNT=DERR_CNT=0.
REQ-025 Outputs after reset SHALL be IN_READY=1, OUT_VALID=0, OUT_BYTE=8'h00.
REQ-026 Reset asserted mid-operation (any state) SHALL discard any partial or pending codeword; no output byte is emitted for it.

Verification
REQ-027 Clean codeword: in 0x0F,0x00 -> out 0x01,0x00; counters unchanged.
REQ-028 Single error (bit 5 flipped): in 0x2F,0x00 -> out 0x01,0x40; CORR_CNT=1.
REQ-029 Overall-parity bit error: in 0x0E,0x00 -> out 0x01,0x40; CORR_CNT increments.
REQ-030 Double error (bits 5 and 6 flipped): in 0x6F,0x00 -> out 0x07,0x80; DERR_CNT=1.
REQ-031 Backpressure: hold OUT_READY=0 for 5 cycles in TX_LO -> OUT_BYTE steady at 0x01 and IN_READY=0 throughout; release -> 0x01 then 0x00 transfer.
REQ-032 Reset in TX_LO -> next cycle OUT_VALID=0, IN_READY=1; then 0x00,0x00 -> out 0x00,0x00.
